uart_rx_to_mat_mem: RTL and testbench
=====================================

Name: uart_rx_to_mat_mem

Overview:
Upstream stage of the result-transmit path. Receives operand matrices A and B over a UART serial line, one byte per element, 8N1 format. Writes each element into the operand memory through a single write port. Raises mat_ready when all elements are stored, so the multiplier can start; the multiplier in turn feeds the memory-to-TX stage.

Parameters:
CLKS_PER_BIT, 10417, clock cycles per UART bit (100 MHz / 9600 baud); the sim bench uses 16.
DATA_W, 8, element and UART payload width.
N_ELEM, 8, total elements received (A[0..3] row-major, then B[0..3]).
ADDR_W, 3, memory address width; must satisfy 2**ADDR_W >= N_ELEM.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
rx_data  input  1  UART serial input; idles high; asynchronous to clk.
load_mat  input  1  level enable; high = accept a matrix load.
mem_wr_en  output  1  one-cycle write strobe.
mem_wr_addr  output  ADDR_W  write address (0-3 = A, 4-7 = B).
mem_wr_data  output  DATA_W  write data.
mat_ready  output  1  high while a complete A/B set is stored.
values_rcvd_count  output  3  count of elements stored so far.
frame_err  output  1  one-cycle pulse on a bad stop bit.
rx_status  output  1  high while a UART frame is in progress.
state_LED  output  5  one-hot FSM state, for board LEDs.

Behaviour:
- Reset (rst=0, async): every output is 0; state_LED=5'b00001 (IDLE); the sub-core returns to idle; the rx_data synchronizer is preset to 1.
- rx_data passes through a 2-FF synchronizer before any use.
- UART core, 8N1, LSB first:
  - Start is detected on a synchronized falling edge.
  - The start bit is re-checked at CLKS_PER_BIT/2. If it reads high, it is treated as a glitch and the core returns to idle without a pulse.
  - Data bits are sampled every CLKS_PER_BIT from that mid-point. The stop bit is sampled the same way.
  - Stop=1: rx_valid pulses for one cycle, in the cycle after the stop-bit sample, with rx_byte.
  - Stop=0: frame_err pulses for one cycle instead; the byte is discarded and the count is not advanced.
  - rx_status is high from start detection to the end of the stop-bit sample.
- Control FSM, with state_LED bits [0..4]:
  - IDLE (bit 0): count=0, mat_ready=0. load_mat=1 -> RECV. Bytes that complete in IDLE are discarded.
  - RECV (bit 1): on rx_valid -> WRITE. If load_mat falls -> IDLE (abort), count cleared, no write.
  - WRITE (bit 2), exactly one cycle:
    - mem_wr_en=1, mem_wr_addr=count, mem_wr_data=latched byte.
    - count increments. If the new count == N_ELEM -> DONE, else -> RECV.
    - Write latency: mem_wr_en is high exactly one cycle after rx_valid.
  - DONE (bit 3): mat_ready=1. Further bytes are ignored. load_mat=0 -> IDLE, clearing mat_ready and count on that transition.
  - ERR (bit 4): entered from RECV on frame_err. Held until load_mat=0, then -> IDLE. The count resets in IDLE.
- values_rcvd_count is 3 bits.
  - It shows 0..7 during a load.
  - On the 8th write the internal counter wraps to 0 and DONE is entered, so the output reads 0 in DONE. Use mat_ready to tell "complete" from "empty".
- load_mat falling mid-frame: the core finishes the frame, but the result is dropped because the FSM is no longer in RECV.
- Reset mid-frame or mid-WRITE: no partial write completes after rst falls; all state is lost.

Decomposition:
- Shared package: FSM state encodings (one-hot localparams IDLE/RECV/WRITE/DONE/ERR); A_BASE=0, B_BASE=4 address constants; default CLKS_PER_BIT. The same package is used by the TX-side block for a consistent state_LED encoding.
- Sub-module uart_rx_core: synchronizer, bit timer, shift register, rx_valid/frame_err/rx_status.
- The top level holds the FSM and write-port logic only.

Test Plan:
- Normal load (CLKS_PER_BIT=16), load_mat=1, send 8 bytes 0x01..0x08 -> eight one-cycle writes at addresses 0..7 with data 0x01..0x08; mat_ready=1, state_LED=5'b01000.
- Bad stop bit on the 3rd byte (0xAA with stop=0) -> frame_err pulses once; no write for that byte; state_LED=5'b10000. Then load_mat=0 -> IDLE with count=0.
- Glitch: a 4-cycle low pulse on rx_data -> no rx_valid, no frame_err, rx_status back to 0 by cycle 8.
- Abort: load_mat falls after 3 bytes -> IDLE, values_rcvd_count=0. Reload with 8 bytes 0x10..0x17 -> addresses 0..7 get 0x10..0x17.
- Bytes sent while load_mat=0, and a 9th byte in DONE -> no mem_wr_en at all.
- rst driven low mid-byte during the 5th element -> all outputs 0 and state_LED=5'b00001 immediately (asynchronous). A fresh load after release restarts at address 0.

Source files
------------

// File: rtl/uart_rx_to_mat_mem_pkg.sv
// Shared encodings for the UART matrix-load path: control FSM states (one-hot, drive
// state_LED directly), UART core states, operand memory base addresses and default baud timing.
package uart_rx_to_mat_mem_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 10417;  // 100 MHz / 9600 baud

  localparam int A_BASE = 0;
  localparam int B_BASE = 4;

  // One-hot so the state register can be shown on the board LEDs without decoding.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_RECV  = 5'b00010,
    ST_WRITE = 5'b00100,
    ST_DONE  = 5'b01000,
    ST_ERR   = 5'b10000
  } ctrl_state_t;

  typedef enum logic [1:0] {
    CORE_IDLE,
    CORE_START,
    CORE_DATA,
    CORE_STOP
  } core_state_t;

endpackage

// File: rtl/uart_rx_to_mat_mem_uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, LSB-first shift register,
// single-cycle rx_valid / frame_err pulses and a frame-in-progress status flag.
module uart_rx_core
  import uart_rx_to_mat_mem_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_byte,
  output logic              frame_err,
  output logic              rx_status
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  core_state_t       state;
  logic              rx_meta;
  logic              rx_sync;
  logic              rx_prev;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift;

  // NOTE: all state here uses non-blocking assignments so every register samples the
  // pre-edge values of the others, exactly like the flip-flops they become.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the synchronizer resets to the idle-line level (1), otherwise releasing
      // reset would look like a falling edge and start a bogus frame.
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= CORE_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_valid  <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
      rx_status <= 1'b0;
    end else begin
      rx_meta   <= rx_data;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      unique case (state)
        CORE_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_sync) begin
            state     <= CORE_START;
            rx_status <= 1'b1;
          end
        end

        // Re-check the start bit at its centre; a high level here was only a glitch.
        CORE_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              state     <= CORE_IDLE;
              rx_status <= 1'b0;
            end else begin
              state <= CORE_DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CORE_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_sync, shift[DATA_W-1:1]};
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              state   <= CORE_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CORE_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt       <= '0;
            state     <= CORE_IDLE;
            rx_status <= 1'b0;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= CORE_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_to_mat_mem.sv
// Receives A then B operand elements over UART and writes them, in arrival order, into
// the operand memory; mat_ready tells the multiplier a full set is stored.
module uart_rx_to_mat_mem
  import uart_rx_to_mat_mem_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = 8,
  parameter int N_ELEM       = 8,
  parameter int ADDR_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_data,
  input  logic              load_mat,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mat_ready,
  output logic [2:0]        values_rcvd_count,
  output logic              frame_err,
  output logic              rx_status,
  output logic [4:0]        state_LED
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_ELEM - 1);

  ctrl_state_t       state;
  logic [ADDR_W-1:0] count;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_byte;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err),
    .rx_status (rx_status)
  );

  assign state_LED         = state;
  assign values_rcvd_count = 3'(count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      count       <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mat_ready   <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          count     <= '0;
          mat_ready <= 1'b0;
          if (load_mat) state <= ST_RECV;
        end

        // The strobe is launched here so it is high during the single WRITE cycle,
        // one cycle after rx_valid.
        ST_RECV: begin
          if (!load_mat) begin
            state <= ST_IDLE;
            count <= '0;
          end else if (frame_err) begin
            state <= ST_ERR;
          end else if (rx_valid) begin
            state       <= ST_WRITE;
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= ADDR_W'(A_BASE) + count;
            mem_wr_data <= rx_byte;
          end
        end

        // The last element wraps the counter to 0; mat_ready distinguishes full from empty.
        ST_WRITE: begin
          if (count == LAST_IDX) begin
            count     <= '0;
            mat_ready <= 1'b1;
            state     <= ST_DONE;
          end else begin
            count <= count + 1'b1;
            state <= ST_RECV;
          end
        end

        ST_DONE: begin
          if (!load_mat) begin
            state     <= ST_IDLE;
            mat_ready <= 1'b0;
            count     <= '0;
          end
        end

        ST_ERR: begin
          if (!load_mat) begin
            state <= ST_IDLE;
            count <= '0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_to_mat_mem.sv
// Self-checking bench: drives 8N1 frames and checks memory writes and status against a
// model in which byte i of an accepted load lands at address i.
module tb_uart_rx_to_mat_mem;

  localparam int CPB    = 16;
  localparam int DATA_W = 8;
  localparam int N_ELEM = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_data = 1'b1;
  logic              load_mat = 1'b0;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mat_ready;
  logic [2:0]        values_rcvd_count;
  logic              frame_err;
  logic              rx_status;
  logic [4:0]        state_LED;

  int checks = 0;
  int failures = 0;

  // Observed write stream and pulse statistics, collected away from the rising edge.
  logic [ADDR_W+DATA_W-1:0] wr_q[$];
  int  wr_total = 0;
  int  wr_long = 0;
  int  ferr_cycles = 0;
  logic prev_wr = 1'b0;

  logic [DATA_W-1:0] exp_bytes[N_ELEM];

  uart_rx_to_mat_mem #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (DATA_W),
    .N_ELEM       (N_ELEM),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .load_mat          (load_mat),
    .mem_wr_en         (mem_wr_en),
    .mem_wr_addr       (mem_wr_addr),
    .mem_wr_data       (mem_wr_data),
    .mat_ready         (mat_ready),
    .values_rcvd_count (values_rcvd_count),
    .frame_err         (frame_err),
    .rx_status         (rx_status),
    .state_LED         (state_LED)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      wr_q.push_back({mem_wr_addr, mem_wr_data});
      wr_total++;
      if (prev_wr) wr_long++;
    end
    if (frame_err === 1'b1) ferr_cycles++;
    prev_wr = (mem_wr_en === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One 8N1 frame followed by one idle bit time; starts and ends on a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_data = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_data = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_data = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_data = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(mem_wr_en), 32'd0);
    check({tag, "_addr"},  32'(mem_wr_addr), 32'd0);
    check({tag, "_data"},  32'(mem_wr_data), 32'd0);
    check({tag, "_ready"}, 32'(mat_ready), 32'd0);
    check({tag, "_count"}, 32'(values_rcvd_count), 32'd0);
    check({tag, "_ferr"},  32'(frame_err), 32'd0);
    check({tag, "_status"}, 32'(rx_status), 32'd0);
    check({tag, "_led"},   32'(state_LED), 32'b00001);
  endtask

  // Sends exp_bytes as a full load and compares the observed writes with the model.
  task automatic load_and_check(input string tag);
    wr_q.delete();
    for (int i = 0; i < N_ELEM; i++) begin
      send_byte(exp_bytes[i], 1'b1);
      if (i < N_ELEM - 1)
        check({tag, "_count"}, 32'(values_rcvd_count), 32'(i + 1));
    end
    check({tag, "_nwr"}, 32'(wr_q.size()), 32'(N_ELEM));
    for (int i = 0; i < N_ELEM && i < wr_q.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_q[i][ADDR_W+DATA_W-1:DATA_W]), 32'(i));
      check({tag, "_data"}, 32'(wr_q[i][DATA_W-1:0]), 32'(exp_bytes[i]));
    end
    check({tag, "_ready"}, 32'(mat_ready), 32'd1);
    check({tag, "_led"}, 32'(state_LED), 32'b01000);
    check({tag, "_cnt_wrap"}, 32'(values_rcvd_count), 32'd0);
  endtask

  initial begin
    int base_wr;
    int base_ferr;

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_led", 32'(state_LED), 32'b00001);

    // Normal load 0x01..0x08
    load_mat = 1'b1;
    repeat (2) @(negedge clk);
    check("recv_led", 32'(state_LED), 32'b00010);
    for (int i = 0; i < N_ELEM; i++) exp_bytes[i] = 8'(i + 1);
    load_and_check("load1");

    // 9th byte in DONE is ignored
    base_wr = wr_total;
    send_byte(8'h5A, 1'b1);
    check("done_ignore_wr", 32'(wr_total), 32'(base_wr));
    check("done_hold_led", 32'(state_LED), 32'b01000);

    load_mat = 1'b0;
    repeat (2) @(negedge clk);
    check("done_exit_led", 32'(state_LED), 32'b00001);
    check("done_exit_ready", 32'(mat_ready), 32'd0);

    // Bytes while load_mat=0 are discarded
    base_wr = wr_total;
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    check("idle_ignore_wr", 32'(wr_total), 32'(base_wr));
    check("idle_ignore_led", 32'(state_LED), 32'b00001);

    // Bad stop bit on the 3rd byte
    load_mat = 1'b1;
    repeat (2) @(negedge clk);
    base_wr = wr_total;
    base_ferr = ferr_cycles;
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'hAA, 1'b0);
    check("ferr_pulse", 32'(ferr_cycles - base_ferr), 32'd1);
    check("ferr_nwr", 32'(wr_total - base_wr), 32'd2);
    check("ferr_led", 32'(state_LED), 32'b10000);
    check("ferr_count", 32'(values_rcvd_count), 32'd2);
    load_mat = 1'b0;
    repeat (2) @(negedge clk);
    check("ferr_exit_led", 32'(state_LED), 32'b00001);
    check("ferr_exit_count", 32'(values_rcvd_count), 32'd0);

    // Glitch: 4-cycle low pulse
    load_mat = 1'b1;
    repeat (2) @(negedge clk);
    base_wr = wr_total;
    base_ferr = ferr_cycles;
    rx_data = 1'b0;
    repeat (4) @(negedge clk);
    rx_data = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_status_hi", 32'(rx_status), 32'd1);
    repeat (14) @(negedge clk);
    check("glitch_status_lo", 32'(rx_status), 32'd0);
    repeat (CPB * 10) @(negedge clk);
    check("glitch_nwr", 32'(wr_total), 32'(base_wr));
    check("glitch_ferr", 32'(ferr_cycles), 32'(base_ferr));
    check("glitch_led", 32'(state_LED), 32'b00010);

    // Abort after 3 bytes, then reload 0x10..0x17
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    check("abort_pre_count", 32'(values_rcvd_count), 32'd3);
    load_mat = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_led", 32'(state_LED), 32'b00001);
    check("abort_count", 32'(values_rcvd_count), 32'd0);
    load_mat = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N_ELEM; i++) exp_bytes[i] = 8'(8'h10 + i);
    load_and_check("reload");
    load_mat = 1'b0;
    repeat (2) @(negedge clk);

    // Random load
    load_mat = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N_ELEM; i++) exp_bytes[i] = 8'($urandom);
    load_and_check("rand");
    load_mat = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-byte during the 5th element
    load_mat = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    rx_data = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    base_wr = wr_total;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    rx_data = 1'b1;
    repeat (CPB * 8) @(negedge clk);
    check("midrst_nwr", 32'(wr_total), 32'(base_wr));
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N_ELEM; i++) exp_bytes[i] = 8'($urandom);
    load_and_check("post_rst");

    check("wr_one_cycle", 32'(wr_long), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
